sdram_port_arbiter: RTL and testbench

Two-port arbiter sharing the single SDRAM controller request port between the RISC5 CPU (single-word read/write) and the video framebuffer fetcher (fixed-length read bursts). It sits in the 100 MHz SDRAM clock domain, between the requesters (already synchronized to this domain) and the SDRAM controller. Video has priority for display continuity. A starvation counter bounds CPU wait time.

---
 rtl/sdram_port_arbiter_pkg.sv | 15 +
 rtl/sdram_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and codes for the SDRAM port arbiter.
// State encodings and owner codes used by the arbiter and its bench.
package sdram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_VID  = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_VID  = 2'b10;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between CPU and video fetcher.
// Video has priority; a starvation counter bounds CPU wait.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int BURST_LEN  = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_sdram,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [31:0]       vid_rdata,
    output logic              vid_done,
    output logic              ctl_req,
    output logic              ctl_we,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [31:0]       ctl_wdata,
    output logic [3:0]        ctl_be,
    input  logic              ctl_ack,
    input  logic [31:0]       ctl_rdata,
    output logic [1:0]        owner
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_LEN - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic              ctl_req_q, ctl_req_d;
    logic              ctl_we_q, ctl_we_d;
    logic [ADDR_W-1:0] ctl_addr_q, ctl_addr_d;
    logic [31:0]       ctl_wdata_q, ctl_wdata_d;
    logic [3:0]        ctl_be_q, ctl_be_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              vid_ack_q, vid_ack_d;
    logic [31:0]       vid_rdata_q, vid_rdata_d;
    logic              vid_done_q, vid_done_d;
    logic [1:0]        owner_q, owner_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [SW-1:0]     starve_q, starve_d;

    logic cpu_go;
    logic vid_go;
    logic vid_win;

    // A requester still completing this cycle cannot be regranted.
    // Video priority uses the raw request, so a held video request
    // keeps the slot through its own done cycle until starved out.
    assign cpu_go  = cpu_req && !cpu_ack_q;
    assign vid_go  = vid_req && !vid_ack_q && !vid_done_q;
    assign vid_win = vid_req && (!cpu_go || (starve_q < STARVE_TOP));

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        ctl_req_d   = ctl_req_q;
        ctl_we_d    = ctl_we_q;
        ctl_addr_d  = ctl_addr_q;
        ctl_wdata_d = ctl_wdata_q;
        ctl_be_d    = ctl_be_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        owner_d     = owner_q;
        beat_d      = beat_q;
        starve_d    = starve_q;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        vid_done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!cpu_go) begin
                    starve_d = '0;
                end
                if (vid_win) begin
                    if (vid_go) begin
                        state_d    = ST_VID;
                        ctl_req_d  = 1'b1;
                        ctl_we_d   = 1'b0;
                        ctl_be_d   = 4'hF;
                        ctl_addr_d = vid_addr;
                        beat_d     = '0;
                        owner_d    = OWN_VID;
                        if (cpu_go && (starve_q != STARVE_TOP)) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                end else if (cpu_go) begin
                    state_d     = ST_CPU;
                    ctl_req_d   = 1'b1;
                    ctl_we_d    = cpu_we;
                    ctl_addr_d  = cpu_addr;
                    ctl_wdata_d = cpu_wdata;
                    ctl_be_d    = cpu_be;
                    owner_d     = OWN_CPU;
                    starve_d    = '0;
                end
            end
            ST_CPU: begin
                if (ctl_ack) begin
                    cpu_rdata_d = ctl_rdata;
                    cpu_ack_d   = 1'b1;
                    ctl_req_d   = 1'b0;
                    owner_d     = OWN_IDLE;
                    state_d     = ST_IDLE;
                end
            end
            ST_VID: begin
                if (ctl_ack) begin
                    vid_rdata_d = ctl_rdata;
                    vid_ack_d   = 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        vid_done_d = 1'b1;
                        ctl_req_d  = 1'b0;
                        owner_d    = OWN_IDLE;
                        state_d    = ST_IDLE;
                    end else begin
                        ctl_addr_d = ctl_addr_q + ADDR_W'(1);
                        beat_d     = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any access.
    always_ff @(posedge clk_sdram or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ctl_req_q   <= 1'b0;
            ctl_we_q    <= 1'b0;
            ctl_addr_q  <= '0;
            ctl_wdata_q <= '0;
            ctl_be_q    <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_ack_q   <= 1'b0;
            vid_rdata_q <= '0;
            vid_done_q  <= 1'b0;
            owner_q     <= OWN_IDLE;
            beat_q      <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            ctl_req_q   <= ctl_req_d;
            ctl_we_q    <= ctl_we_d;
            ctl_addr_q  <= ctl_addr_d;
            ctl_wdata_q <= ctl_wdata_d;
            ctl_be_q    <= ctl_be_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_ack_q   <= vid_ack_d;
            vid_rdata_q <= vid_rdata_d;
            vid_done_q  <= vid_done_d;
            owner_q     <= owner_d;
            beat_q      <= beat_d;
            starve_q    <= starve_d;
        end
    end

    assign ctl_req   = ctl_req_q;
    assign ctl_we    = ctl_we_q;
    assign ctl_addr  = ctl_addr_q;
    assign ctl_wdata = ctl_wdata_q;
    assign ctl_be    = ctl_be_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_ack   = vid_ack_q;
    assign vid_rdata = vid_rdata_q;
    assign vid_done  = vid_done_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: controller model plus scoreboards.
// Expected requests and responses are queued as stimulus is driven.
module tb_sdram_port_arbiter;
    import sdram_port_arbiter_pkg::*;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_wd;
    } ctl_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } vid_t;

    logic        clk_sdram;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        vid_req;
    logic [23:0] vid_addr;
    logic        vid_ack;
    logic [31:0] vid_rdata;
    logic        vid_done;
    logic        ctl_req;
    logic        ctl_we;
    logic [23:0] ctl_addr;
    logic [31:0] ctl_wdata;
    logic [3:0]  ctl_be;
    logic        ctl_ack;
    logic [31:0] ctl_rdata;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int ack_delay = 0;
    int cpu_ack_cnt = 0;
    int vid_ack_cnt = 0;
    int vid_done_cnt = 0;
    int cpu_grant_cyc = 0;
    int vid_grant_cyc = 0;
    int vid_done_cyc = 0;
    logic [1:0] prev_owner = 2'b00;

    ctl_t       ctl_exp[$];
    logic [31:0] cpu_exp[$];
    vid_t       vid_exp[$];
    logic [1:0] grant_log[$];

    sdram_port_arbiter #(
        .ADDR_W(24), .BURST_LEN(8), .STARVE_MAX(4)
    ) dut (
        .clk_sdram(clk_sdram), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ack(vid_ack), .vid_rdata(vid_rdata), .vid_done(vid_done),
        .ctl_req(ctl_req), .ctl_we(ctl_we), .ctl_addr(ctl_addr),
        .ctl_wdata(ctl_wdata), .ctl_be(ctl_be),
        .ctl_ack(ctl_ack), .ctl_rdata(ctl_rdata),
        .owner(owner)
    );

    initial begin
        clk_sdram = 1'b0;
        forever #5 clk_sdram = ~clk_sdram;
    end

    always @(posedge clk_sdram) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        return {8'h5A, a} ^ 32'h00C3_3C00;
    endfunction

    task automatic exp_cpu(input logic we, input logic [23:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        ctl_exp.push_back('{we, a, wd, be, 1'b1});
        cpu_exp.push_back(mem_word(a));
    endtask

    task automatic exp_burst(input logic [23:0] a);
        logic [23:0] b;
        for (int i = 0; i < 8; i++) begin
            b = a + 24'(i);
            ctl_exp.push_back('{1'b0, b, 32'h0, 4'hF, 1'b0});
            vid_exp.push_back('{mem_word(b), (i == 7)});
        end
    endtask

    // Controller model: acks after ack_delay idle cycles, checks fields.
    initial begin
        int wcnt;
        ctl_t e;
        wcnt = 0;
        ctl_ack = 1'b0;
        ctl_rdata = '0;
        forever begin
            @(negedge clk_sdram);
            ctl_ack = 1'b0;
            if (rst || !ctl_req) begin
                wcnt = 0;
            end else if (wcnt >= ack_delay) begin
                wcnt = 0;
                ctl_ack = 1'b1;
                ctl_rdata = mem_word(ctl_addr);
                if (ctl_exp.size() == 0) begin
                    check("ctl_unexpected", 1, 0);
                end else begin
                    e = ctl_exp.pop_front();
                    check("ctl_we", ctl_we, e.we);
                    check("ctl_addr", ctl_addr, e.addr);
                    check("ctl_be", ctl_be, e.be);
                    if (e.chk_wd) check("ctl_wdata", ctl_wdata, e.wdata);
                end
            end else begin
                wcnt++;
            end
        end
    end

    // Response monitor: grants, CPU and video completions.
    always @(negedge clk_sdram) begin
        vid_t v;
        if (!rst) begin
            if (owner != prev_owner && owner != OWN_IDLE) begin
                check("grant_gap", prev_owner, OWN_IDLE);
                grant_log.push_back(owner);
                if (owner == OWN_CPU) cpu_grant_cyc = cyc;
                else vid_grant_cyc = cyc;
            end
            if (cpu_ack) begin
                cpu_ack_cnt++;
                if (cpu_exp.size() == 0) check("cpu_ack_unexp", 1, 0);
                else check("cpu_rdata", cpu_rdata, cpu_exp.pop_front());
            end
            if (vid_ack) begin
                vid_ack_cnt++;
                if (vid_exp.size() == 0) begin
                    check("vid_ack_unexp", 1, 0);
                end else begin
                    v = vid_exp.pop_front();
                    check("vid_rdata", vid_rdata, v.data);
                    check("vid_done_flag", vid_done, v.last);
                end
                if (vid_done) begin
                    vid_done_cnt++;
                    vid_done_cyc = cyc;
                end
            end else if (vid_done) begin
                check("vid_done_noack", 1, 0);
            end
        end
        prev_owner = owner;
    end

    // Run until target counts reached; requesters drop on completion.
    task automatic run(input int vd_tgt, input int ca_tgt,
                       input string tag);
        int n;
        bit drop_cpu;
        n = 0;
        drop_cpu = 0;
        while ((vid_done_cnt < vd_tgt || cpu_ack_cnt < ca_tgt ||
                cpu_req || vid_req) && n < 3000) begin
            @(negedge clk_sdram);
            #1;
            n++;
            if (drop_cpu) begin
                cpu_req = 1'b0;
                drop_cpu = 0;
            end
            if (cpu_ack && cpu_ack_cnt >= ca_tgt) drop_cpu = 1;
            if (vid_done && vid_done_cnt >= vd_tgt) vid_req = 1'b0;
        end
        check({tag, "_timeout"}, (n < 3000), 1);
        repeat (4) @(negedge clk_sdram);
        #1;
    endtask

    initial begin
        int base_vd;
        int base_ca;
        int n;
        logic [1:0] pat [6];
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0;
        cpu_wdata = '0; cpu_be = '0;
        vid_req = 0; vid_addr = '0;
        repeat (3) @(negedge clk_sdram);
        #1;
        check("rst_owner", owner, OWN_IDLE);
        check("rst_ctl_req", ctl_req, 0);
        check("rst_ctl_addr", ctl_addr, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_vid_ack", vid_ack, 0);
        check("rst_vid_done", vid_done, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_vid_rdata", vid_rdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_sdram);
        #1;

        // CPU write, held through its ack cycle
        ack_delay = 2;
        grant_log.delete();
        base_ca = cpu_ack_cnt;
        exp_cpu(1'b1, 24'h000100, 32'hDEADBEEF, 4'b0011);
        cpu_we = 1; cpu_addr = 24'h000100;
        cpu_wdata = 32'hDEADBEEF; cpu_be = 4'b0011;
        cpu_req = 1;
        run(vid_done_cnt, base_ca + 1, "t1");
        check("t1_acks", cpu_ack_cnt - base_ca, 1);
        check("t1_grants", grant_log.size(), 1);
        check("t1_owner", owner, OWN_IDLE);
        check("t1_ctl_left", ctl_exp.size(), 0);

        // Video burst wrapping the address space, back-to-back acks
        ack_delay = 0;
        grant_log.delete();
        base_vd = vid_done_cnt;
        exp_burst(24'hFFFFFC);
        vid_addr = 24'hFFFFFC;
        vid_req = 1;
        run(base_vd + 1, cpu_ack_cnt, "t2");
        check("t2_grants", grant_log.size(), 1);
        check("t2_burst_cycles", vid_done_cyc - vid_grant_cyc, 8);
        check("t2_vid_left", vid_exp.size(), 0);
        check("t2_ctl_left", ctl_exp.size(), 0);

        // Simultaneous requests: video first, CPU one cycle after done
        ack_delay = 1;
        grant_log.delete();
        base_vd = vid_done_cnt;
        base_ca = cpu_ack_cnt;
        exp_burst(24'h000300);
        exp_cpu(1'b0, 24'h000400, 32'h12345678, 4'hF);
        vid_addr = 24'h000300;
        cpu_we = 0; cpu_addr = 24'h000400;
        cpu_wdata = 32'h12345678; cpu_be = 4'hF;
        vid_req = 1;
        cpu_req = 1;
        run(base_vd + 1, base_ca + 1, "t3");
        check("t3_grants", grant_log.size(), 2);
        check("t3_first_vid", grant_log[0], OWN_VID);
        check("t3_gap", cpu_grant_cyc - vid_done_cyc, 1);

        // Starvation: held video request, CPU waits 4 bursts
        ack_delay = 0;
        grant_log.delete();
        base_vd = vid_done_cnt;
        base_ca = cpu_ack_cnt;
        for (int i = 0; i < 4; i++) exp_burst(24'h000040);
        exp_cpu(1'b0, 24'h000200, 32'h0, 4'hF);
        exp_burst(24'h000040);
        vid_addr = 24'h000040;
        cpu_addr = 24'h000200; cpu_wdata = '0;
        vid_req = 1;
        cpu_req = 1;
        run(base_vd + 5, base_ca + 1, "t4");
        pat = '{OWN_VID, OWN_VID, OWN_VID, OWN_VID, OWN_CPU, OWN_VID};
        check("t4_grants", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t4_grant%0d", i),
                  (i < grant_log.size()) ? grant_log[i] : 2'b11,
                  pat[i]);
        end
        check("t4_ctl_left", ctl_exp.size(), 0);

        // Reset at beat 3 of a burst
        ack_delay = 1;
        base_vd = vid_done_cnt;
        n = vid_ack_cnt;
        exp_burst(24'h000500);
        vid_addr = 24'h000500;
        vid_req = 1;
        for (int i = 0; i < 500 && vid_ack_cnt < n + 3; i++) begin
            @(negedge clk_sdram);
            #1;
        end
        check("t5_wait", vid_ack_cnt - n, 3);
        #1;
        rst = 1'b1;
        #1;
        check("t5_owner", owner, OWN_IDLE);
        check("t5_ctl_req", ctl_req, 0);
        check("t5_ctl_addr", ctl_addr, 0);
        check("t5_vid_ack", vid_ack, 0);
        check("t5_vid_rdata", vid_rdata, 0);
        check("t5_pending", ctl_exp.size(), 5);
        ctl_exp.delete();
        vid_exp.delete();
        vid_req = 0;
        repeat (2) @(negedge clk_sdram);
        rst = 1'b0;
        repeat (2) @(negedge clk_sdram);
        #1;
        check("t5_no_done", vid_done_cnt, base_vd);

        // Fresh burst after reset starts at beat 0
        ack_delay = 0;
        grant_log.delete();
        exp_burst(24'h000080);
        vid_addr = 24'h000080;
        vid_req = 1;
        run(base_vd + 1, cpu_ack_cnt, "t6");
        check("t6_grants", grant_log.size(), 1);
        check("t6_vid_left", vid_exp.size(), 0);
        check("t6_ctl_left", ctl_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
